// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory op codes, FSM states
// and big-endian byte-lane enables.
package mem_lsu_pkg;

    localparam int MemOpBus = 4;

    localparam logic [MemOpBus-1:0] MEM_OP_NONE = 4'd0;
    localparam logic [MemOpBus-1:0] MEM_OP_LB   = 4'd1;
    localparam logic [MemOpBus-1:0] MEM_OP_LBU  = 4'd2;
    localparam logic [MemOpBus-1:0] MEM_OP_LH   = 4'd3;
    localparam logic [MemOpBus-1:0] MEM_OP_LHU  = 4'd4;
    localparam logic [MemOpBus-1:0] MEM_OP_LW   = 4'd5;
    localparam logic [MemOpBus-1:0] MEM_OP_SB   = 4'd6;
    localparam logic [MemOpBus-1:0] MEM_OP_SH   = 4'd7;
    localparam logic [MemOpBus-1:0] MEM_OP_SW   = 4'd8;

    // Lane enables: byte address 0 lives in bits [31:24].
    localparam logic [3:0] LANE_B0   = 4'b1000;
    localparam logic [3:0] LANE_H0   = 4'b1100;
    localparam logic [3:0] LANE_H1   = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: byte enables, store replication, load extension
// and alignment check for one memory op.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misaligned_o,
    output logic        is_load_o,
    output logic        is_store_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    always_comb begin
        rd_byte = 8'h00;
        case (addr_lo_i)
            2'b00:   rd_byte = rdata_i[31:24];
            2'b01:   rd_byte = rdata_i[23:16];
            2'b10:   rd_byte = rdata_i[15:8];
            default: rd_byte = rdata_i[7:0];
        endcase
        rd_half  = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        byte_sel = LANE_B0 >> addr_lo_i;
        half_sel = addr_lo_i[1] ? LANE_H1 : LANE_H0;
    end

    always_comb begin
        sel_o        = 4'b0000;
        wdata_o      = sdata_i;
        ldata_o      = rdata_i;
        misaligned_o = 1'b0;
        is_load_o    = 1'b0;
        is_store_o   = 1'b0;
        case (op_i)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
                sel_o   = byte_sel;
                wdata_o = {4{sdata_i[7:0]}};
                ldata_o = {{24{rd_byte[7] & (op_i == MEM_OP_LB)}}, rd_byte};
            end
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
                sel_o        = half_sel;
                wdata_o      = {2{sdata_i[15:0]}};
                ldata_o      = {{16{rd_half[15] & (op_i == MEM_OP_LH)}}, rd_half};
                misaligned_o = addr_lo_i[0];
            end
            MEM_OP_LW, MEM_OP_SW: begin
                sel_o        = LANE_WORD;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase
        is_load_o  = (op_i == MEM_OP_LB) || (op_i == MEM_OP_LBU) || (op_i == MEM_OP_LH) ||
                     (op_i == MEM_OP_LHU) || (op_i == MEM_OP_LW);
        is_store_o = (op_i == MEM_OP_SB) || (op_i == MEM_OP_SH) || (op_i == MEM_OP_SW);
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: passes ALU results to MEM/WB, runs load/store req/ack transactions on the
// data bus with upstream stall, flags misaligned accesses and bus timeouts.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_whilo,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        stallreq,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_whilo,
    output logic        wb_adel,
    output logic        wb_ades,
    output logic        wb_buserr
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    lsu_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] baddr_q, baddr_d, bwdata_q, bwdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  lo2_q, lo2_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [4:0]  wb_wd_q, wb_wd_d;
    logic        wb_wreg_q, wb_wreg_d, wb_whilo_q, wb_whilo_d;
    logic [31:0] wb_wdata_q, wb_wdata_d, wb_hi_q, wb_hi_d, wb_lo_q, wb_lo_d;
    logic        adel_q, adel_d, ades_q, ades_d, buserr_q, buserr_d;
    logic        stall_d;

    logic [3:0]  al_op;
    logic [1:0]  al_lo;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata, al_ldata;
    logic        al_mis, al_load, al_store;
    logic        timeout_hit;

    // While BUSY the latched op drives the aligner so extension never depends on held inputs.
    assign al_op = (state_q == ST_BUSY) ? op_q : mem_op;
    assign al_lo = (state_q == ST_BUSY) ? lo2_q : mem_addr[1:0];

    mem_lsu_align u_align (
        .op_i         (al_op),
        .addr_lo_i    (al_lo),
        .sdata_i      (mem_sdata),
        .rdata_i      (dbus_rdata),
        .sel_o        (al_sel),
        .wdata_o      (al_wdata),
        .ldata_o      (al_ldata),
        .misaligned_o (al_mis),
        .is_load_o    (al_load),
        .is_store_o   (al_store)
    );

    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        baddr_d    = baddr_q;
        sel_d      = sel_q;
        bwdata_d   = bwdata_q;
        op_d       = op_q;
        lo2_d      = lo2_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        wb_hi_d    = wb_hi_q;
        wb_lo_d    = wb_lo_q;
        wb_whilo_d = wb_whilo_q;
        adel_d     = 1'b0;
        ades_d     = 1'b0;
        buserr_d   = 1'b0;
        stall_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wb_wd_d    = mem_wd;
                wb_wdata_d = mem_wdata;
                wb_hi_d    = mem_hi;
                wb_lo_d    = mem_lo;
                if (al_load || al_store) begin
                    // Memory ops write back nothing this edge: either a fault or a bubble.
                    wb_wreg_d  = 1'b0;
                    wb_whilo_d = 1'b0;
                    if (al_mis) begin
                        adel_d = al_load;
                        ades_d = al_store;
                    end else begin
                        stall_d  = 1'b1;
                        req_d    = 1'b1;
                        we_d     = al_store;
                        baddr_d  = {mem_addr[31:2], 2'b00};
                        sel_d    = al_sel;
                        bwdata_d = al_wdata;
                        op_d     = mem_op;
                        lo2_d    = mem_addr[1:0];
                        wd_d     = mem_wd;
                        wreg_d   = mem_wreg;
                        cnt_d    = '0;
                        state_d  = ST_BUSY;
                    end
                end else begin
                    wb_wreg_d  = mem_wreg;
                    wb_whilo_d = mem_whilo;
                end
            end
            default: begin
                if (dbus_ack) begin
                    req_d      = 1'b0;
                    wb_wd_d    = wd_q;
                    wb_wreg_d  = wreg_q & al_load;
                    wb_wdata_d = al_load ? al_ldata : 32'h0;
                    wb_whilo_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (timeout_hit) begin
                    req_d      = 1'b0;
                    buserr_d   = 1'b1;
                    wb_wreg_d  = 1'b0;
                    wb_whilo_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    stall_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            baddr_q    <= 32'h0;
            sel_q      <= 4'h0;
            bwdata_q   <= 32'h0;
            op_q       <= MEM_OP_NONE;
            lo2_q      <= 2'b00;
            wd_q       <= 5'h0;
            wreg_q     <= 1'b0;
            wb_wd_q    <= 5'h0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= 32'h0;
            wb_hi_q    <= 32'h0;
            wb_lo_q    <= 32'h0;
            wb_whilo_q <= 1'b0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            baddr_q    <= baddr_d;
            sel_q      <= sel_d;
            bwdata_q   <= bwdata_d;
            op_q       <= op_d;
            lo2_q      <= lo2_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            wb_hi_q    <= wb_hi_d;
            wb_lo_q    <= wb_lo_d;
            wb_whilo_q <= wb_whilo_d;
            adel_q     <= adel_d;
            ades_q     <= ades_d;
            buserr_q   <= buserr_d;
        end
    end

    assign stallreq   = stall_d;
    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = baddr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = bwdata_q;
    assign wb_wd      = wb_wd_q;
    assign wb_wreg    = wb_wreg_q;
    assign wb_wdata   = wb_wdata_q;
    assign wb_hi      = wb_hi_q;
    assign wb_lo      = wb_lo_q;
    assign wb_whilo   = wb_whilo_q;
    assign wb_adel    = adel_q;
    assign wb_ades    = ades_q;
    assign wb_buserr  = buserr_q;

endmodule
